// File: rtl/sclk_burst_divider_if.sv
// ============================================================================
// Module   : sclk_burst_divider_if
// Purpose  : Control/status bundle between the ADC control FSM and the
//            sclk burst divider. The cpol wire exists only when
//            SCLK_BURST_DIVIDER_CPOL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sclk_burst_divider_if #(
  parameter int BURST_W = 8
);
  logic               enable;
  logic [1:0]         sel;
  logic               free_run;
  logic               start;
  logic [BURST_W-1:0] n_periods;
`ifdef SCLK_BURST_DIVIDER_CPOL_EN
  logic               cpol;
`endif
  logic               sclk;
  logic               lead_stb;
  logic               trail_stb;
  logic               busy;
  logic               done;

`ifdef SCLK_BURST_DIVIDER_CPOL_EN
  modport master (
    output enable, sel, free_run, start, n_periods, cpol,
    input  sclk, lead_stb, trail_stb, busy, done
  );
  modport slave (
    input  enable, sel, free_run, start, n_periods, cpol,
    output sclk, lead_stb, trail_stb, busy, done
  );
`else
  modport master (
    output enable, sel, free_run, start, n_periods,
    input  sclk, lead_stb, trail_stb, busy, done
  );
  modport slave (
    input  enable, sel, free_run, start, n_periods,
    output sclk, lead_stb, trail_stb, busy, done
  );
`endif

endinterface

`default_nettype wire

// File: rtl/sclk_burst_divider.sv
// ============================================================================
// Module   : sclk_burst_divider
// Purpose  : Serial ADC bit-clock generator with table-selected half-period,
//            free-running or N-period burst mode, and edge strobes.
//            Define SCLK_BURST_DIVIDER_CPOL_EN to add a cpol-selected idle level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sclk_burst_divider #(
  parameter int DIV_W   = 16,
  parameter int DIV0    = 128,
  parameter int DIV1    = 64,
  parameter int DIV2    = 32,
  parameter int DIV3    = 16,
  parameter int BURST_W = 8
) (
  input  wire logic             clk_in,
  input  wire logic             reset,
  sclk_burst_divider_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [DIV_W-1:0]   count_q,     count_d;
  logic [DIV_W-1:0]   half_q,      half_d;
  logic [BURST_W-1:0] remain_q,    remain_d;
  logic               burst_q,     burst_d;
  logic               sclk_q,      sclk_d;
  logic               lead_q,      lead_d;
  logic               trail_q,     trail_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               done_pend_q, done_pend_d;

  // Idle level used while running, and the level to park at while idle.
  logic               idle_run;
  logic               idle_park;

  logic [DIV_W-1:0]   sel_half;
  logic               half_end;

  // A zero table entry would never terminate a half-period; run it as 1.
  function automatic logic [DIV_W-1:0] half_of(input logic [1:0] s);
    logic [DIV_W-1:0] v;
    v = DIV_W'(DIV0);
    case (s)
      2'b00: v = DIV_W'(DIV0);
      2'b01: v = DIV_W'(DIV1);
      2'b10: v = DIV_W'(DIV2);
      2'b11: v = DIV_W'(DIV3);
    endcase
    if (v == '0) begin
      v = DIV_W'(1);
    end
    return v;
  endfunction

  assign sel_half = half_of(bus.sel);
  assign half_end = (count_q == (half_q - DIV_W'(1)));

`ifdef SCLK_BURST_DIVIDER_CPOL_EN
  logic cpol_q, cpol_d;

  always_comb begin
    cpol_d = cpol_q;
    if (bus.enable && (state_q == S_IDLE)) begin
      cpol_d = bus.cpol;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cpol_q <= 1'b0;
    end else begin
      cpol_q <= cpol_d;
    end
  end

  assign idle_run  = cpol_q;
  assign idle_park = bus.cpol;
`else
  assign idle_run  = 1'b0;
  assign idle_park = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    half_d      = half_q;
    remain_d    = remain_q;
    burst_d     = burst_q;
    sclk_d      = sclk_q;
    lead_d      = 1'b0;
    trail_d     = 1'b0;
    done_d      = 1'b0;
    done_pend_d = done_pend_q;

    if (bus.enable) begin
      done_d      = done_pend_q;
      done_pend_d = 1'b0;

      case (state_q)
        S_IDLE: begin
          count_d = '0;
          sclk_d  = idle_park;
          if (bus.free_run) begin
            state_d = S_RUN;
            half_d  = sel_half;
            burst_d = 1'b0;
          end else if (bus.start) begin
            if (bus.n_periods == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = S_RUN;
              half_d   = sel_half;
              remain_d = bus.n_periods;
              burst_d  = 1'b1;
            end
          end
        end

        S_RUN: begin
          if (bus.free_run) begin
            burst_d = 1'b0;
          end
          if (half_end) begin
            count_d = '0;
            sclk_d  = ~sclk_q;
            if (sclk_q == idle_run) begin
              lead_d = 1'b1;
            end else begin
              // Trailing edge: the only point where a new divisor or a stop is honoured.
              trail_d = 1'b1;
              half_d  = sel_half;
              if (bus.free_run) begin
                state_d = S_RUN;
              end else if (burst_q) begin
                remain_d = remain_q - BURST_W'(1);
                if (remain_q == BURST_W'(1)) begin
                  state_d     = S_IDLE;
                  done_pend_d = 1'b1;
                end
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            count_d = count_q + DIV_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      half_q      <= DIV_W'(1);
      remain_q    <= '0;
      burst_q     <= 1'b0;
      sclk_q      <= 1'b0;
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      half_q      <= half_d;
      remain_q    <= remain_d;
      burst_q     <= burst_d;
      sclk_q      <= sclk_d;
      lead_q      <= lead_d;
      trail_q     <= trail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign bus.sclk      = sclk_q;
  assign bus.lead_stb  = lead_q;
  assign bus.trail_stb = trail_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire
